// File: rtl/cordic_ci_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_ci_sequencer
//
// Multi-cycle custom-instruction front end for the CORDIC cosine accelerator.
// A single-precision angle is accepted from the CPU and checked for range. The
// sequencer then drives the external float->fixed converter, launches the
// iterative CORDIC core, and passes the core result through the external
// fixed->float converter. The float result is returned with a done pulse that
// lasts one enabled cycle.
//
// Parameters
//   FX_W     fixed-point width (sign, 1 integer bit, FX_W-2 fraction bits)
//   TIMEOUT  enabled cycles allowed in WAIT for core_done before abort
//   NAN_VAL  result returned for an invalid operand or a core timeout
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   clk_en      clock enable; low freezes every register
//   start       request pulse, only honoured in IDLE
//   dataa       IEEE-754 single operand (angle in radians)
//   done        result valid (high for one enabled cycle)
//   result      IEEE-754 single cos(dataa)
//   err         sticky: last operation was invalid or timed out
//   ft2fx_in    operand to the external float->fixed converter
//   ft2fx_out   float->fixed converter output
//   core_start  one-cycle launch strobe to the CORDIC core
//   core_ang    angle to the core, stable from launch until core_done
//   core_done   core result valid, single-cycle pulse
//   core_res    core fixed-point cosine
//   fx2ft_in    value to the external fixed->float converter
//   fx2ft_out   fixed->float converter output
// -----------------------------------------------------------------------------
module cordic_ci_sequencer #(
    parameter int          FX_W    = 24,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            start,
    input  logic [31:0]     dataa,
    output logic            done,
    output logic [31:0]     result,
    output logic            err,
    output logic [31:0]     ft2fx_in,
    input  logic [FX_W-1:0] ft2fx_out,
    output logic            core_start,
    output logic [FX_W-1:0] core_ang,
    input  logic            core_done,
    input  logic [FX_W-1:0] core_res,
    output logic [FX_W-1:0] fx2ft_in,
    input  logic [31:0]     fx2ft_out
);

    // The wait counter must be able to hold TIMEOUT-1, the value at which the
    // last permitted WAIT cycle is evaluated.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Largest magnitude accepted: the bit pattern of +1.0 with the sign removed.
    localparam logic [30:0] MAG_ONE = 31'h3F800000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CVT_IN,
        ST_LAUNCH,
        ST_WAIT,
        ST_CVT_OUT,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t           state;
    logic [31:0]      op_reg;
    logic [FX_W-1:0]  ang_reg;
    logic [FX_W-1:0]  res_fx;
    logic [31:0]      result_reg;
    logic             err_reg;
    logic [CNT_W-1:0] wait_cnt;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t           state_next;
    logic [31:0]      op_next;
    logic [FX_W-1:0]  ang_next;
    logic [FX_W-1:0]  res_fx_next;
    logic [31:0]      result_next;
    logic             err_next;
    logic [CNT_W-1:0] wait_cnt_next;

    logic             op_invalid;

    // An operand is rejected when it is Inf/NaN (all-ones exponent) or when
    // its magnitude exceeds 1.0. Comparing the raw bit patterns is enough
    // because IEEE-754 magnitudes order the same way as their encodings.
    // Exactly 1.0 is still accepted.
    assign op_invalid = (op_reg[30:23] == 8'hFF) || (op_reg[30:0] > MAG_ONE);

    // -------------------------------------------------------------------------
    // Next-state and datapath decisions. Every register keeps its value unless
    // the current state explicitly updates it.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        op_next       = op_reg;
        ang_next      = ang_reg;
        res_fx_next   = res_fx;
        result_next   = result_reg;
        err_next      = err_reg;
        wait_cnt_next = wait_cnt;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    op_next    = dataa;
                    err_next   = 1'b0;
                    state_next = ST_CVT_IN;
                end
            end

            ST_CVT_IN: begin
                // Invalid operands skip the core entirely.
                if (op_invalid) begin
                    result_next = NAN_VAL;
                    err_next    = 1'b1;
                    state_next  = ST_DONE;
                end else begin
                    ang_next   = ft2fx_out;
                    state_next = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end

            ST_WAIT: begin
                // core_done is checked before the timeout so that a result
                // arriving on the last permitted cycle is still accepted.
                if (core_done) begin
                    res_fx_next = core_res;
                    state_next  = ST_CVT_OUT;
                end else if (wait_cnt == CNT_LAST) begin
                    result_next = NAN_VAL;
                    err_next    = 1'b1;
                    state_next  = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            ST_CVT_OUT: begin
                result_next = fx2ft_out;
                state_next  = ST_DONE;
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register bank. clk_en low holds everything, including the FSM, so a
    // pending done stays visible until an enabled edge consumes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_reg     <= '0;
            ang_reg    <= '0;
            res_fx     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            wait_cnt   <= '0;
        end else if (clk_en) begin
            state      <= state_next;
            op_reg     <= op_next;
            ang_reg    <= ang_next;
            res_fx     <= res_fx_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. core_start is qualified with clk_en so the core sees exactly
    // one launch edge, and it falls as soon as reset forces the FSM to IDLE.
    // -------------------------------------------------------------------------
    assign done       = (state == ST_DONE);
    assign core_start = (state == ST_LAUNCH) && clk_en;
    assign core_ang   = ang_reg;
    assign result     = result_reg;
    assign err        = err_reg;
    assign ft2fx_in   = op_reg;
    assign fx2ft_in   = res_fx;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cordic_ci_sequencer
//
// Directed bench for cordic_ci_sequencer. Behavioural models stand in for the
// two converters and the CORDIC core. The core model answers from a small
// table of hand-computed cosines after a programmable number of enabled
// cycles. Expected results are hand-computed IEEE-754 constants.
//
// Latency is counted in enabled rising edges after the edge that samples
// start, up to the edge that raises done. A valid operation takes L+3 edges
// (CVT_IN, LAUNCH, L cycles in WAIT, CVT_OUT). An invalid operand goes
// straight from CVT_IN to DONE in 1 edge, so done is high in the second cycle
// counting the start cycle.
// -----------------------------------------------------------------------------
module tb_cordic_ci_sequencer;

    localparam int FX_W = 24;

    localparam logic [31:0] F_NAN     = 32'h7FC00000;
    localparam logic [31:0] F_ONE     = 32'h3F800000;
    localparam logic [31:0] F_COS_Q   = 32'h3F780AA4;  // cos(0.25) = 0.968912
    localparam logic [31:0] F_COS_ONE = 32'h3F0A5140;  // cos(1.0)  = 0.540302

    logic            clk = 1'b0;
    logic            reset;
    logic            clk_en;
    logic            start;
    logic [31:0]     dataa;
    logic            done;
    logic [31:0]     result;
    logic            err;
    logic [31:0]     ft2fx_in;
    logic [FX_W-1:0] ft2fx_out;
    logic            core_start;
    logic [FX_W-1:0] core_ang;
    logic            core_done;
    logic [FX_W-1:0] core_res;
    logic [FX_W-1:0] fx2ft_in;
    logic [31:0]     fx2ft_out;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Core model state. A core_lat of 0 means the core never answers.
    int   core_lat = 16;
    int   core_cnt;
    logic core_busy;
    logic stray_done = 1'b0;

    always #5 clk = ~clk;

    cordic_ci_sequencer #(
        .FX_W    (FX_W),
        .TIMEOUT (64),
        .NAN_VAL (32'h7FC00000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .done       (done),
        .result     (result),
        .err        (err),
        .ft2fx_in   (ft2fx_in),
        .ft2fx_out  (ft2fx_out),
        .core_start (core_start),
        .core_ang   (core_ang),
        .core_done  (core_done),
        .core_res   (core_res),
        .fx2ft_in   (fx2ft_in),
        .fx2ft_out  (fx2ft_out)
    );

    // Float -> Q1.22 for magnitudes up to 1.0, truncating.
    function automatic logic [FX_W-1:0] ft_to_fx(input logic [31:0] f);
        logic [7:0]      e;
        logic [FX_W-1:0] m;
        logic [FX_W-1:0] mag;
        e = f[30:23];
        m = {1'b1, f[22:0]};
        if (e == 8'd0 || e > 8'd127) mag = '0;
        else                         mag = m >> (8'd128 - e);
        return f[31] ? -mag : mag;
    endfunction

    // Q1.22 -> float, truncating.
    function automatic logic [31:0] fx_to_ft(input logic [FX_W-1:0] x);
        logic            s;
        logic [FX_W-1:0] mag;
        logic [FX_W-1:0] sh;
        int              p;
        if (x == '0) return 32'h0;
        s   = x[FX_W-1];
        mag = s ? -x : x;
        p   = 0;
        for (int i = 0; i < FX_W; i++) if (mag[i]) p = i;
        sh = mag << (23 - p);
        return {s, 8'(p + 105), sh[22:0]};
    endfunction

    // Hand-computed Q1.22 cosines for the angles used below.
    function automatic logic [FX_W-1:0] cos_lut(input logic [FX_W-1:0] a);
        case (a)
            24'h000000:             return 24'h400000;
            24'h100000, 24'hF00000: return 24'h3E02A9;
            24'h400000:             return 24'h229450;
            default:                return 24'h000000;
        endcase
    endfunction

    assign ft2fx_out = ft_to_fx(ft2fx_in);
    assign fx2ft_out = fx_to_ft(fx2ft_in);
    assign core_res  = cos_lut(core_ang);
    assign core_done = (core_busy && core_cnt == 1) || stray_done;

    // Core model: core_done is raised in the cycle L enabled cycles after the
    // core_start cycle. The model shares the sequencer reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (clk_en) begin
            if (core_start && core_lat > 0) begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat;
            end else if (core_busy) begin
                if (core_cnt == 1) core_busy <= 1'b0;
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation. It holds start until an enabled edge samples it,
    // then counts enabled edges and launch strobes until done appears. With
    // poke set, start stays high and dataa changes while the sequencer is
    // busy; both must be ignored.
    task automatic applyStimulus(input string tag, input logic [31:0] operand,
                                 input int latency, input bit jitter, input bit poke,
                                 output int lat, output int starts);
        bit en_now;
        bit got;
        core_lat = latency;
        lat      = 0;
        starts   = 0;
        got      = 1'b0;
        dataa    = operand;
        start    = 1'b1;
        en_now   = 1'b0;
        while (!en_now) begin
            en_now = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            clk_en = en_now;
            next_cycle();
        end
        start = poke;
        if (poke) dataa = 32'h3F000000;
        for (int i = 0; i < 400 && !got; i++) begin
            en_now = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            clk_en = en_now;
            #1;
            if (core_start) starts++;
            next_cycle();
            if (en_now) lat++;
            if (done) got = 1'b1;
        end
        start  = 1'b0;
        clk_en = 1'b0;
        checkOutput({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    // done must survive disabled cycles and drop after one enabled edge.
    task automatic check_done_pulse(input string tag);
        clk_en = 1'b0;
        next_cycle();
        next_cycle();
        checkOutput({tag, "_done_held"}, 64'(done), 64'd1);
        clk_en = 1'b1;
        next_cycle();
        checkOutput({tag, "_done_drop"}, 64'(done), 64'd0);
        clk_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int starts;

        reset  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_ctrl",   64'({done, core_start, err}), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_ang",    64'(core_ang), 64'd0);
        checkOutput("reset_ft2fx",  64'(ft2fx_in), 64'd0);
        reset = 1'b1;
        next_cycle();

        // Test 1: 0.25 with L=16
        applyStimulus("t1", 32'h3E800000, 16, 1'b0, 1'b0, lat, starts);
        checkOutput("t1_latency", 64'(lat), 64'd19);
        checkOutput("t1_result",  64'(result), 64'(F_COS_Q));
        checkOutput("t1_err",     64'(err), 64'd0);
        checkOutput("t1_starts",  64'(starts), 64'd1);
        check_done_pulse("t1");

        // Test 2: -0.25, start held and dataa changed while busy
        applyStimulus("t2", 32'hBE800000, 16, 1'b0, 1'b1, lat, starts);
        checkOutput("t2_latency", 64'(lat), 64'd19);
        checkOutput("t2_result",  64'(result), 64'(F_COS_Q));
        checkOutput("t2_starts",  64'(starts), 64'd1);
        check_done_pulse("t2");

        // Test 3: invalid operands 2.0, NaN and just above 1.0
        applyStimulus("t3_two", 32'h40000000, 16, 1'b0, 1'b0, lat, starts);
        checkOutput("t3_two_latency", 64'(lat), 64'd1);
        checkOutput("t3_two_result",  64'(result), 64'(F_NAN));
        checkOutput("t3_two_err",     64'(err), 64'd1);
        checkOutput("t3_two_starts",  64'(starts), 64'd0);
        check_done_pulse("t3_two");

        applyStimulus("t3_nan", 32'h7FC00000, 16, 1'b0, 1'b0, lat, starts);
        checkOutput("t3_nan_latency", 64'(lat), 64'd1);
        checkOutput("t3_nan_result",  64'(result), 64'(F_NAN));
        checkOutput("t3_nan_err",     64'(err), 64'd1);
        checkOutput("t3_nan_starts",  64'(starts), 64'd0);
        check_done_pulse("t3_nan");

        // Exactly 1.0 is valid and must also clear the sticky err.
        applyStimulus("t3_one", 32'h3F800000, 4, 1'b0, 1'b0, lat, starts);
        checkOutput("t3_one_latency", 64'(lat), 64'd7);
        checkOutput("t3_one_result",  64'(result), 64'(F_COS_ONE));
        checkOutput("t3_one_err",     64'(err), 64'd0);
        check_done_pulse("t3_one");

        applyStimulus("t3_above", 32'hBF800001, 4, 1'b0, 1'b0, lat, starts);
        checkOutput("t3_above_result", 64'(result), 64'(F_NAN));
        checkOutput("t3_above_err",    64'(err), 64'd1);
        checkOutput("t3_above_starts", 64'(starts), 64'd0);
        check_done_pulse("t3_above");

        // Test 4: the core never answers, so WAIT times out after 64 cycles.
        applyStimulus("t4_timeout", 32'h3E800000, 0, 1'b0, 1'b0, lat, starts);
        checkOutput("t4_timeout_latency", 64'(lat), 64'd66);
        checkOutput("t4_timeout_result",  64'(result), 64'(F_NAN));
        checkOutput("t4_timeout_err",     64'(err), 64'd1);
        check_done_pulse("t4_timeout");

        // core_done on the 64th WAIT cycle wins over the timeout.
        applyStimulus("t4_edge", 32'h3E800000, 64, 1'b0, 1'b0, lat, starts);
        checkOutput("t4_edge_latency", 64'(lat), 64'd67);
        checkOutput("t4_edge_result",  64'(result), 64'(F_COS_Q));
        checkOutput("t4_edge_err",     64'(err), 64'd0);
        check_done_pulse("t4_edge");

        // A stray core_done while IDLE must change nothing.
        clk_en     = 1'b1;
        stray_done = 1'b1;
        next_cycle();
        stray_done = 1'b0;
        next_cycle();
        checkOutput("stray_done_flag", 64'(done), 64'd0);
        checkOutput("stray_result",    64'(result), 64'(F_COS_Q));
        clk_en = 1'b0;

        // Test 5: test 1 repeated with clk_en randomly toggled
        applyStimulus("t5", 32'h3E800000, 16, 1'b1, 1'b0, lat, starts);
        checkOutput("t5_latency", 64'(lat), 64'd19);
        checkOutput("t5_result",  64'(result), 64'(F_COS_Q));
        checkOutput("t5_starts",  64'(starts), 64'd1);
        check_done_pulse("t5");

        // Test 6: reset five cycles into WAIT
        core_lat = 16;
        dataa    = 32'h3E800000;
        start    = 1'b1;
        clk_en   = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (7) next_cycle();
        checkOutput("t6_busy", 64'(done), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_ctrl",   64'({done, core_start, err}), 64'd0);
        checkOutput("t6_rst_result", 64'(result), 64'd0);
        checkOutput("t6_rst_ang",    64'(core_ang), 64'd0);
        checkOutput("t6_rst_ft2fx",  64'(ft2fx_in), 64'd0);
        checkOutput("t6_rst_fx2ft",  64'(fx2ft_in), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        applyStimulus("t6_zero", 32'h00000000, 16, 1'b0, 1'b0, lat, starts);
        checkOutput("t6_zero_latency", 64'(lat), 64'd19);
        checkOutput("t6_zero_result",  64'(result), 64'(F_ONE));
        checkOutput("t6_zero_err",     64'(err), 64'd0);
        check_done_pulse("t6_zero");

        // Reset during LAUNCH: core_start must fall without a clock edge.
        dataa  = 32'h3E800000;
        start  = 1'b1;
        clk_en = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        #1;
        checkOutput("launch_seen", 64'(core_start), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("launch_async_drop", 64'(core_start), 64'd0);
        @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
